// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async-FIFO sizing and gray-code helper
package fifo_pkg;
    localparam int ADDRSIZE = 4;
    localparam int PTRW = ADDRSIZE + 1;
    function automatic logic [31:0] gray_enc(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational prefix-XOR gray-to-binary decoder
module gray2bin #(
    parameter int WIDTH = fifo_pkg::PTRW
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end
endmodule

// File: rtl/rptr_empty_level.sv
// rptr_empty_level: read-side pointer, empty/almost-empty, level and underflow status
module rptr_empty_level
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = fifo_pkg::ADDRSIZE,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);
    localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE + 1)'(AEMPTY_THRESH);
    logic [ADDRSIZE:0] rbin, rbinnext, rgraynext, wbin_s, rlevel_next;
    logic [31:0] gray32;
    logic rpop;
    gray2bin #(.WIDTH(ADDRSIZE + 1)) u_wdec (.gray(rq2_wptr), .bin(wbin_s));
    always_comb begin
        rpop = rinc & ~rempty;
        rbinnext = rbin + {{ADDRSIZE{1'b0}}, rpop};
        gray32 = gray_enc(32'(rbinnext));
        rgraynext = gray32[ADDRSIZE:0];
        // level is against the synchronized (stale) write pointer, so it can only under-report
        rlevel_next = wbin_s - rbinnext;
    end
    assign raddr = rbin[ADDRSIZE-1:0];
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin <= '0;
            rptr <= '0;
            rempty <= 1'b1;
            raempty <= 1'b1;
            rlevel <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin <= rbinnext;
            rptr <= rgraynext;
            rempty <= rgraynext == rq2_wptr;
            raempty <= rlevel_next <= THRESH;
            rlevel <= rlevel_next;
            runderflow <= runderflow | (rinc & rempty);
        end
    end
endmodule

// File: tb/tb_rptr_empty_level.sv
// tb_rptr_empty_level: directed table vectors plus modelled wrap and full-depth sequences
module tb_rptr_empty_level;
    logic rclk = 1'b0, rrst = 1'b1, rinc = 1'b0;
    logic [4:0] rq2_wptr = '0;
    logic [3:0] raddr;
    logic [4:0] rptr, rlevel;
    logic rempty, raempty, runderflow;
    int checks = 0, errors = 0;
    typedef struct {
        logic rst, inc;
        logic [4:0] wb;
        logic [3:0] addr;
        logic [4:0] ptr;
        logic emp, aemp;
        logic [4:0] lvl;
        logic uf;
    } tv_t;
    tv_t tv[16];
    logic [4:0] m_rb, m_wb, m_lvl;
    logic m_emp, m_uf, pop;

    rptr_empty_level dut (
        .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
        .raddr(raddr), .rptr(rptr), .rempty(rempty), .raempty(raempty),
        .rlevel(rlevel), .runderflow(runderflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] a, input logic [4:0] p,
                           input logic e, input logic ae, input logic [4:0] l, input logic u);
        chk({tag, " raddr"}, int'(raddr), int'(a));
        chk({tag, " rptr"}, int'(rptr), int'(p));
        chk({tag, " rempty"}, int'(rempty), int'(e));
        chk({tag, " raempty"}, int'(raempty), int'(ae));
        chk({tag, " rlevel"}, int'(rlevel), int'(l));
        chk({tag, " runderflow"}, int'(runderflow), int'(u));
        chk({tag, " empty_vs_level"}, int'(rempty), int'(rlevel == 5'd0));
    endtask

    task automatic step(input string tag, input logic rst, input logic inc, input logic [4:0] wb);
        rrst = rst;
        rinc = inc;
        rq2_wptr = g(wb);
        @(posedge rclk);
        if (rst) begin
            m_rb = '0; m_uf = 1'b0; m_emp = 1'b1; m_lvl = '0;
        end else begin
            pop = inc & ~m_emp;
            m_uf = m_uf | (inc & m_emp);
            m_rb = m_rb + {4'd0, pop};
            m_lvl = wb - m_rb;
            m_emp = m_lvl == 5'd0;
        end
        m_wb = wb;
        #1;
        chk_all(tag, m_rb[3:0], g(m_rb), rst ? 1'b1 : m_emp, rst ? 1'b1 : (m_lvl <= 5'd2), m_lvl, m_uf);
    endtask

    initial begin
        tv[0]  = '{1, 1, 4, 0, 0, 1, 1, 0, 0};
        tv[1]  = '{1, 1, 4, 0, 0, 1, 1, 0, 0};
        tv[2]  = '{1, 1, 4, 0, 0, 1, 1, 0, 0};
        tv[3]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        tv[4]  = '{0, 0, 1, 0, 0, 0, 1, 1, 0};
        tv[5]  = '{0, 0, 2, 0, 0, 0, 1, 2, 0};
        tv[6]  = '{0, 0, 3, 0, 0, 0, 0, 3, 0};
        tv[7]  = '{0, 1, 3, 1, 1, 0, 1, 2, 0};
        tv[8]  = '{0, 1, 3, 2, 3, 0, 1, 1, 0};
        tv[9]  = '{0, 1, 3, 3, 2, 1, 1, 0, 0};
        tv[10] = '{0, 1, 3, 3, 2, 1, 1, 0, 1};
        tv[11] = '{0, 1, 3, 3, 2, 1, 1, 0, 1};
        tv[12] = '{0, 0, 4, 3, 2, 0, 1, 1, 1};
        tv[13] = '{0, 1, 5, 4, 6, 0, 1, 1, 1};
        tv[14] = '{0, 1, 5, 5, 7, 1, 1, 0, 1};
        tv[15] = '{1, 0, 5, 0, 0, 1, 1, 0, 0};
        for (int i = 0; i < 16; i++) begin
            rrst = tv[i].rst;
            rinc = tv[i].inc;
            rq2_wptr = g(tv[i].wb);
            @(posedge rclk);
            #1;
            chk_all($sformatf("vec%0d", i), tv[i].addr, tv[i].ptr, tv[i].emp, tv[i].aemp, tv[i].lvl, tv[i].uf);
        end
        // wrap-around: write while level<5, read three cycles of four, long enough for rbin to wrap
        step("wrap_rst", 1'b1, 1'b0, 5'd0);
        step("wrap_prime", 1'b0, 1'b0, 5'd1);
        for (int i = 0; i < 90; i++)
            step($sformatf("wrap%0d", i), 1'b0, (i % 4) != 3, m_lvl < 5'd5 ? m_wb + 5'd1 : m_wb);
        chk("wrap_reads", int'(m_rb < 5'd20), 1);
        // full depth: write pointer jumps to 16 with rbin=0, then 16 pops
        step("full_rst", 1'b1, 1'b0, 5'd0);
        step("full_fill", 1'b0, 1'b0, 5'd16);
        chk("full_level", int'(rlevel), 16);
        chk("full_aempty", int'(raempty), 0);
        for (int i = 0; i < 16; i++)
            step($sformatf("drain%0d", i), 1'b0, 1'b1, 5'd16);
        chk("drain_rptr", int'(rptr), 5'b11000);
        chk("drain_empty", int'(rempty), 1);
        step("drain_over", 1'b0, 1'b1, 5'd16);
        chk("drain_uf", int'(runderflow), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
